// File: rtl/artemis_ddr3_burst_ctrl.sv
// Burst controller splitting user read/write transfers into MCB commands of up to BURST_MAX words.
// One command in flight at a time; any port fault while busy aborts the transfer with a sticky error.
module artemis_ddr3_burst_ctrl #(
    parameter int BURST_MAX = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calibration_done,
    input  logic        req_start,
    input  logic        req_write,
    input  logic [29:0] req_addr,
    input  logic [23:0] req_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        p_cmd_en,
    output logic [2:0]  p_cmd_instr,
    output logic [5:0]  p_cmd_bl,
    output logic [29:0] p_cmd_byte_addr,
    input  logic        p_cmd_full,
    output logic        p_wr_en,
    output logic [3:0]  p_wr_mask,
    output logic [31:0] p_wr_data,
    input  logic        p_wr_full,
    input  logic        p_wr_underrun,
    input  logic        p_wr_error,
    output logic        p_rd_en,
    input  logic [31:0] p_rd_data,
    input  logic        p_rd_empty,
    input  logic        p_rd_overflow,
    input  logic        p_rd_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_FILL  = 3'd1,
        S_WR_CMD   = 3'd2,
        S_RD_CMD   = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      state_r, state_n_s;
    logic [29:0] addr_r;
    logic [23:0] remaining_r;
    logic [6:0]  chunk_r, fill_cnt_r, drain_cnt_r;
    logic        busy_r, done_r, error_r;
    logic        cmd_en_r;
    logic [2:0]  cmd_instr_r;
    logic [5:0]  cmd_bl_r;
    logic [29:0] cmd_addr_r;

    logic        active_s, fault_s, accept_s, issue_s, advance_s;
    logic        wr_ready_s, rd_valid_s, wr_beat_s, rd_beat_s;
    logic [23:0] rem_after_s, rem_load_s;
    logic [6:0]  chunk_next_s;

    assign active_s = (state_r == S_WR_FILL) || (state_r == S_WR_CMD) ||
                      (state_r == S_RD_CMD)  || (state_r == S_RD_DRAIN);
    assign fault_s  = active_s && (p_wr_underrun || p_wr_error || p_rd_overflow ||
                                   p_rd_error || !calibration_done);

    // Chunk for the next burst comes from req_count on accept, otherwise from what is left
    assign rem_after_s  = remaining_r - {17'd0, chunk_r};
    assign rem_load_s   = (state_r == S_IDLE) ? req_count : rem_after_s;
    assign chunk_next_s = (rem_load_s < 24'(BURST_MAX)) ? rem_load_s[6:0] : 7'(BURST_MAX);

    // Next-state and stream handshake decode
    always_comb begin
        state_n_s  = state_r;
        accept_s   = 1'b0;
        issue_s    = 1'b0;
        advance_s  = 1'b0;
        wr_ready_s = 1'b0;
        rd_valid_s = 1'b0;
        if (fault_s) begin
            state_n_s = S_DONE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_start && calibration_done) begin
                        accept_s = 1'b1;
                        if (req_count == 24'd0) begin
                            state_n_s = S_DONE;
                        end else if (req_write) begin
                            state_n_s = S_WR_FILL;
                        end else begin
                            state_n_s = S_RD_CMD;
                        end
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                S_WR_FILL: begin
                    wr_ready_s = !p_wr_full && (fill_cnt_r < chunk_r);
                    if (fill_cnt_r == chunk_r) begin
                        state_n_s = S_WR_CMD;
                    end else begin
                        state_n_s = S_WR_FILL;
                    end
                end
                S_WR_CMD: begin
                    if (!p_cmd_full) begin
                        issue_s   = 1'b1;
                        advance_s = 1'b1;
                        state_n_s = (rem_after_s == 24'd0) ? S_DONE : S_WR_FILL;
                    end else begin
                        state_n_s = S_WR_CMD;
                    end
                end
                S_RD_CMD: begin
                    if (!p_cmd_full) begin
                        issue_s   = 1'b1;
                        state_n_s = S_RD_DRAIN;
                    end else begin
                        state_n_s = S_RD_CMD;
                    end
                end
                S_RD_DRAIN: begin
                    rd_valid_s = !p_rd_empty && (drain_cnt_r < chunk_r);
                    if (drain_cnt_r == chunk_r) begin
                        advance_s = 1'b1;
                        state_n_s = (rem_after_s == 24'd0) ? S_DONE : S_RD_CMD;
                    end else begin
                        state_n_s = S_RD_DRAIN;
                    end
                end
                S_DONE:  state_n_s = S_IDLE;
                default: state_n_s = S_IDLE;
            endcase
        end
    end

    assign wr_beat_s = wr_valid && wr_ready_s;
    assign rd_beat_s = rd_valid_s && rd_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Transfer bookkeeping and registered MCB command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= 30'd0;
            remaining_r <= 24'd0;
            chunk_r     <= 7'd0;
            fill_cnt_r  <= 7'd0;
            drain_cnt_r <= 7'd0;
            cmd_en_r    <= 1'b0;
            cmd_instr_r <= 3'b000;
            cmd_bl_r    <= 6'd0;
            cmd_addr_r  <= 30'd0;
        end else begin
            cmd_en_r <= issue_s;
            if (issue_s) begin
                cmd_instr_r <= (state_r == S_WR_CMD) ? 3'b000 : 3'b001;
                cmd_bl_r    <= 6'(chunk_r - 7'd1);
                cmd_addr_r  <= addr_r;
            end
            if (accept_s) begin
                addr_r      <= req_addr & 30'h3FFF_FFFC;
                remaining_r <= req_count;
            end else if (advance_s) begin
                addr_r      <= addr_r + {21'd0, chunk_r, 2'b00};
                remaining_r <= rem_after_s;
            end
            if ((state_n_s == S_WR_FILL && state_r != S_WR_FILL) ||
                (state_n_s == S_RD_CMD && state_r != S_RD_CMD)) begin
                chunk_r <= chunk_next_s;
            end
            if (state_r != S_WR_FILL) begin
                fill_cnt_r <= 7'd0;
            end else if (wr_beat_s) begin
                fill_cnt_r <= fill_cnt_r + 7'd1;
            end
            if (state_r != S_RD_DRAIN) begin
                drain_cnt_r <= 7'd0;
            end else if (rd_beat_s) begin
                drain_cnt_r <= drain_cnt_r + 7'd1;
            end
        end
    end

    // Status flags; error is sticky until the next accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            busy_r <= (state_n_s == S_WR_FILL) || (state_n_s == S_WR_CMD) ||
                      (state_n_s == S_RD_CMD)  || (state_n_s == S_RD_DRAIN);
            done_r <= (state_n_s == S_DONE);
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (fault_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign wr_ready        = wr_ready_s;
    assign rd_valid        = rd_valid_s;
    assign rd_data         = p_rd_data;
    assign p_wr_en         = wr_beat_s;
    assign p_wr_data       = wr_data;
    assign p_wr_mask       = 4'h0;
    assign p_rd_en         = rd_beat_s;
    assign p_cmd_en        = cmd_en_r;
    assign p_cmd_instr     = cmd_instr_r;
    assign p_cmd_bl        = cmd_bl_r;
    assign p_cmd_byte_addr = cmd_addr_r;

endmodule

// File: tb/tb_artemis_ddr3_burst_ctrl.sv
// Randomized bench for artemis_ddr3_burst_ctrl: a queue-based MCB model plus a
// transfer-level reference (expected command list, memory image, read stream).
module tb_artemis_ddr3_burst_ctrl;

    localparam int BMAX = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calibration_done, req_start, req_write;
    logic [29:0] req_addr;
    logic [23:0] req_count;
    logic        busy, done, error;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        p_cmd_en;
    logic [2:0]  p_cmd_instr;
    logic [5:0]  p_cmd_bl;
    logic [29:0] p_cmd_byte_addr;
    logic        p_cmd_full;
    logic        p_wr_en;
    logic [3:0]  p_wr_mask;
    logic [31:0] p_wr_data;
    logic        p_wr_full, p_wr_underrun, p_wr_error;
    logic        p_rd_en;
    logic [31:0] p_rd_data;
    logic        p_rd_empty, p_rd_overflow, p_rd_error;

    artemis_ddr3_burst_ctrl #(.BURST_MAX(BMAX)) dut (
        .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
        .req_start(req_start), .req_write(req_write), .req_addr(req_addr),
        .req_count(req_count), .busy(busy), .done(done), .error(error),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
        .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
        .p_wr_en(p_wr_en), .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data),
        .p_wr_full(p_wr_full), .p_wr_underrun(p_wr_underrun), .p_wr_error(p_wr_error),
        .p_rd_en(p_rd_en), .p_rd_data(p_rd_data), .p_rd_empty(p_rd_empty),
        .p_rd_overflow(p_rd_overflow), .p_rd_error(p_rd_error)
    );

    always #5 clk = ~clk;

    int n_cmp, n_err;
    int pct_cmd_full, pct_wr_full, pct_rd_gap, pct_wv_gap, pct_rr_gap;
    logic        x_write;
    logic [29:0] x_addr;
    int          x_count, widx, ridx, done_cnt, viol;
    logic [31:0] wsrc[$];
    logic [31:0] wrq[$];
    logic [31:0] rdq[$];
    logic [38:0] cmd_log[$];
    logic [31:0] mem [logic [29:0]];
    logic        hold_mode, inj_rd_err;
    int          hold_ctr, held_en;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [46:0] outvec();
        return {busy, done, error, p_cmd_en, p_wr_en, p_rd_en, wr_ready, rd_valid,
                p_cmd_instr, p_cmd_bl, p_cmd_byte_addr};
    endfunction

    task automatic clear_model(input logic wr, input logic [29:0] a, input int cnt);
        x_write = wr; x_addr = a & 30'h3FFF_FFFC; x_count = cnt;
        wsrc.delete(); wrq.delete(); rdq.delete(); cmd_log.delete(); mem.delete();
        for (int i = 0; i < cnt; i++) wsrc.push_back($urandom());
        widx = 0; ridx = 0; done_cnt = 0; viol = 0; hold_ctr = 0; held_en = 0;
    endtask

    // One clock: drive MCB/user inputs, observe settled outputs, update the MCB model, advance
    task automatic step();
        logic held;
        held       = hold_mode && x_write && (widx == x_count) && (hold_ctr < 10);
        p_cmd_full = held || ($urandom_range(99) < pct_cmd_full);
        if (held) hold_ctr++;
        p_wr_full  = ($urandom_range(99) < pct_wr_full);
        p_rd_empty = (rdq.size() == 0) || ($urandom_range(99) < pct_rd_gap);
        p_rd_data  = (rdq.size() == 0) ? 32'd0 : rdq[0];
        wr_valid   = x_write && (widx < x_count) && !($urandom_range(99) < pct_wv_gap);
        wr_data    = (widx < wsrc.size()) ? wsrc[widx] : 32'hDEAD_BEEF;
        rd_ready   = !($urandom_range(99) < pct_rr_gap);
        p_rd_error = inj_rd_err;
        #1;
        if (inj_rd_err) check_eq("fault_gating", {p_rd_en, p_wr_en, rd_valid, wr_ready}, 4'b0000);
        if (p_cmd_en) begin
            cmd_log.push_back({p_cmd_instr, p_cmd_bl, p_cmd_byte_addr});
            if (held) held_en++;
            for (int i = 0; i <= int'(p_cmd_bl); i++) begin
                if (p_cmd_instr == 3'b000) begin
                    if (wrq.size() == 0) viol++;
                    else mem[p_cmd_byte_addr + 30'(4 * i)] = wrq.pop_front();
                end else begin
                    rdq.push_back(rd_word(p_cmd_byte_addr + 30'(4 * i)));
                end
            end
        end
        if (p_wr_en) begin
            if (p_wr_full || p_wr_mask != 4'h0) viol++;
            wrq.push_back(p_wr_data);
            widx++;
        end
        if (p_rd_en) begin
            if (p_rd_empty) viol++;
            else begin
                void'(rdq.pop_front());
                check_eq("rd_data", rd_data, rd_word(x_addr + 30'(4 * ridx)));
                ridx++;
            end
        end
        if (done) done_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic begin_xfer(input logic wr, input logic [29:0] a, input int cnt);
        clear_model(wr, a, cnt);
        req_write = wr; req_addr = a; req_count = 24'(cnt); req_start = 1'b1;
        step();
        req_start = 1'b0;
        check_eq("busy_on_accept", busy, cnt != 0);
        check_eq("error_cleared", error, 1'b0);
    endtask

    task automatic finish_xfer(input logic stray);
        int cyc, k, rem, ch;
        logic [29:0] a;
        logic [38:0] expc, gotc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            if (stray && cyc == 5) begin
                req_start = 1'b1; req_write = !x_write; req_addr = 30'h0ABC_0000; req_count = 24'd5;
            end else begin
                req_start = 1'b0;
            end
            step();
            cyc++;
        end
        req_start = 1'b0;
        if (done_cnt == 0) check_eq("timeout", 1'b1, 1'b0);
        check_eq("idle_after_done", {busy, done, error}, 3'b000);
        repeat (2) step();
        check_eq("done_once", done_cnt, 1);
        rem = x_count; a = x_addr; k = 0;
        while (rem > 0) begin
            ch   = (rem < BMAX) ? rem : BMAX;
            expc = {x_write ? 3'b000 : 3'b001, 6'(ch - 1), a};
            gotc = (k < cmd_log.size()) ? cmd_log[k] : 39'h7F_FFFF_FFFF;
            check_eq("cmd", gotc, expc);
            a = a + 30'(4 * ch); rem -= ch; k++;
        end
        check_eq("cmd_count", cmd_log.size(), k);
        if (x_write) begin
            check_eq("wr_beats", widx, x_count);
            for (int i = 0; i < x_count; i++) begin
                logic [29:0] wa;
                wa = x_addr + 30'(4 * i);
                check_eq("wr_mem", mem.exists(wa) ? mem[wa] : ~wsrc[i], wsrc[i]);
            end
        end else begin
            check_eq("rd_beats", ridx, x_count);
        end
        check_eq("protocol_viol", viol, 0);
    endtask

    task automatic run_xfer(input logic wr, input logic [29:0] a, input int cnt, input logic stray);
        begin_xfer(wr, a, cnt);
        finish_xfer(stray);
    endtask

    initial begin
        int cyc, n_rd, n_cmd, cnt;
        logic [29:0] a;
        n_cmp = 0; n_err = 0;
        pct_cmd_full = 0; pct_wr_full = 0; pct_rd_gap = 0; pct_wv_gap = 0; pct_rr_gap = 0;
        hold_mode = 1'b0; inj_rd_err = 1'b0;
        rst_n = 1'b0; calibration_done = 1'b1;
        req_start = 1'b0; req_write = 1'b0; req_addr = 30'd0; req_count = 24'd0;
        wr_data = 32'd0; wr_valid = 1'b0; rd_ready = 1'b0;
        p_cmd_full = 1'b0; p_wr_full = 1'b0; p_wr_underrun = 1'b0; p_wr_error = 1'b0;
        p_rd_data = 32'd0; p_rd_empty = 1'b1; p_rd_overflow = 1'b0; p_rd_error = 1'b0;
        clear_model(1'b0, 30'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", outvec(), 47'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_xfer(1'b1, 30'h100, 3, 1'b0);
        run_xfer(1'b0, 30'h0, 130, 1'b0);

        hold_mode = 1'b1;
        run_xfer(1'b1, 30'h2000, 20, 1'b0);
        hold_mode = 1'b0;
        check_eq("cmd_full_no_issue", held_en, 0);
        check_eq("cmd_full_held", hold_ctr, 10);

        run_xfer(1'b1, 30'h0000_4003, 40, 1'b1);
        run_xfer(1'b0, 30'h0000_6000, 70, 1'b1);

        // Request with calibration low must be ignored
        clear_model(1'b0, 30'd0, 0);
        calibration_done = 1'b0;
        req_start = 1'b1; req_write = 1'b1; req_addr = 30'h40; req_count = 24'd4;
        step();
        req_start = 1'b0;
        repeat (10) step();
        check_eq("nocal_ignored", {busy, error, done_cnt[7:0], cmd_log.size()}, 42'd0);
        calibration_done = 1'b1;
        step();

        // Read error during drain aborts with a sticky error
        begin_xfer(1'b0, 30'h800, 100);
        cyc = 0;
        while (ridx < 5 && cyc < 2000) begin
            step();
            cyc++;
        end
        check_eq("fault_setup", ridx, 5);
        inj_rd_err = 1'b1;
        step();
        inj_rd_err = 1'b0;
        check_eq("fault_done", {done, error, busy}, 3'b110);
        n_rd = ridx; n_cmd = cmd_log.size();
        repeat (6) step();
        check_eq("fault_sticky", {error, busy, done}, 3'b100);
        check_eq("fault_no_rd", ridx, n_rd);
        check_eq("fault_no_cmd", cmd_log.size(), n_cmd);
        check_eq("fault_done_once", done_cnt, 1);
        run_xfer(1'b1, 30'h900, 5, 1'b0);

        // Asynchronous reset in the middle of a write fill
        begin_xfer(1'b1, 30'h1000, 10);
        cyc = 0;
        while (widx < 3 && cyc < 200) begin
            step();
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset", outvec(), 47'd0);
        @(posedge clk); #1;
        check_eq("reset_hold", outvec(), 47'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(1'b1, 30'h1000, 10, 1'b0);

        run_xfer(1'b1, 30'h3FFF_FFF8, 70, 1'b0);
        run_xfer(1'b0, 30'h3FFF_FFF0, 66, 1'b0);

        for (int t = 0; t < 24; t++) begin
            pct_cmd_full = int'($urandom_range(40));
            pct_wr_full  = int'($urandom_range(40));
            pct_rd_gap   = int'($urandom_range(40));
            pct_wv_gap   = int'($urandom_range(40));
            pct_rr_gap   = int'($urandom_range(40));
            cnt = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : int'($urandom_range(200, 1));
            a   = ($urandom_range(4) == 0) ? (30'h3FFF_FF00 | 30'($urandom_range(255))) : 30'($urandom());
            run_xfer(1'($urandom_range(1)), a, cnt, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/artemis_ddr3_burst_ctrl.md
ARTEMIS_DDR3_BURST_CTRL -- requirements
Module: artemis_ddr3_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_MAX, default 64, max words per MCB command (legal 1..64).
REQ-002 SHALL have ports, one per line, as listed below.
- clk  in  1  sole clock; also drives MCB port cmd/wr/rd clocks externally.
- rst_n  in  1  asynchronous, active-low reset.
- calibration_done  in  1  DDR3 controller calibrated.
- req_start  in  1  single-cycle transfer request.
- req_write  in  1  1 = write DDR3, 0 = read.
- req_addr  in  30  start byte address; bits[1:0] forced 0.
- req_count  in  24  transfer length in 32-bit words.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky fault flag.
- wr_data / wr_valid / wr_ready  in 32 / in 1 / out 1  user write stream.
- rd_data / rd_valid / rd_ready  out 32 / out 1 / in 1  user read stream.
- p_cmd_en, p_cmd_instr[2:0], p_cmd_bl[5:0], p_cmd_byte_addr[29:0]  out  MCB command.
- p_cmd_full  in  1.
- p_wr_en, p_wr_mask[3:0], p_wr_data[31:0]  out; p_wr_full, p_wr_underrun, p_wr_error  in.
- p_rd_en  out; p_rd_data[31:0], p_rd_empty, p_rd_overflow, p_rd_error  in.

Function
REQ-003 SHALL accept req_start only in IDLE with calibration_done=1; otherwise ignore it (no state change, no done).
REQ-004 On accept: latch addr (bits[1:0]=0), remaining=req_count, direction; clear error; busy=1 from next cycle.
REQ-005 req_count=0: go to DONE directly, no MCB command issued.
REQ-006 States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, DONE; chunk = min(remaining, BURST_MAX), computed on entry to WR_FILL/RD_CMD.
REQ-007 WR_FILL: wr_ready = !p_wr_full && fill_cnt<chunk (combinational); p_wr_en = wr_valid && wr_ready; p_wr_data = wr_data; p_wr_mask = 4'h0; fill_cnt==chunk -> WR_CMD.
REQ-008 WR_CMD: when !p_cmd_full, pulse p_cmd_en exactly one cycle, instr 3'b000, bl=chunk-1, byte_addr=current addr; then addr += 4*chunk (mod 2^30), remaining -= chunk; remaining==0 -> DONE else WR_FILL.
REQ-009 RD_CMD: when !p_cmd_full, pulse p_cmd_en one cycle, instr 3'b001, bl=chunk-1 -> RD_DRAIN.
REQ-010 RD_DRAIN: rd_valid = !p_rd_empty && drain_cnt<chunk; p_rd_en = rd_valid && rd_ready; rd_data = p_rd_data; drain_cnt==chunk -> update addr/remaining as REQ-008, next RD_CMD or DONE.
REQ-011 At most one read command outstanding; next read command only after previous chunk fully drained.
REQ-012 p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr SHALL be registered; instr/bl/addr stable while p_cmd_en=1.
REQ-013 DONE: done=1 one cycle, busy=0 same cycle, then IDLE.
REQ-014 While busy, any of p_wr_underrun, p_wr_error, p_rd_overflow, p_rd_error, or calibration_done=0 -> error=1, abort to DONE next cycle; no further p_cmd_en/p_wr_en/p_rd_en.
REQ-015 error held until next accepted req_start.
REQ-016 wr_ready/rd_valid SHALL be 0 in every state except WR_FILL/RD_DRAIN respectively.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE; busy, done, error, p_cmd_en, p_wr_en, p_rd_en, wr_ready, rd_valid = 0; p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, counters = 0.
REQ-018 Reset mid-transfer SHALL not flush MCB FIFOs; stale contents are software's responsibility.

Verification
REQ-019 Write req_addr=0x100, count=3, wr_valid held high -> 3 p_wr_en beats, then one p_cmd_en instr=000 bl=2 addr=0x100, done pulse.
REQ-020 Read addr=0x0, count=130, BURST_MAX=64 -> commands bl=63 @0x0, bl=63 @0x100, bl=1 @0x200; 130 rd beats in order; done once.
REQ-021 Write with p_cmd_full high 10 cycles in WR_CMD -> p_cmd_en delayed until full drops, single pulse, no data loss.
REQ-022 req_start while busy, or with calibration_done=0 -> ignored, no command, no done.
REQ-023 p_rd_error pulse during RD_DRAIN -> error=1, done pulse next cycle, error stays 1 until next accepted start.
REQ-024 rst_n low during WR_FILL -> all outputs 0 asynchronously; after release req_start accepted normally.
